watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

Time-setting controller that sequences the watch timekeeping datapath (the block with run-enable, sec/min/hour outputs). It owns the datapath's run enable, pauses counting while the user edits hours, minutes and seconds with button pulses, and then loads the edited time back in one cycle. It sits between the debounced button front-end and the watch counter block.

## Interface
- P_SEC_BIT, 6, seconds field width
- P_MIN_BIT, 6, minutes field width
- P_HOUR_BIT, 5, hours field width
- P_TIMEOUT_BIT, 30, inactivity counter width (used only with the timeout feature)
- P_TIMEOUT_CYC, 1000000, idle cycles before an edit is abandoned

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- i_mode  in  1  single-cycle pulse: enter edit, or advance to the next field
- i_up  in  1  single-cycle pulse: increment the selected field
- i_down  in  1  single-cycle pulse: decrement the selected field
- i_cancel  in  1  single-cycle pulse: abandon the edit
- i_sec / i_min / i_hour  in  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  current time from the datapath
- o_run_en  out  1  run enable to the datapath
- o_load  out  1  single-cycle load strobe to the datapath
- o_set_sec / o_set_min / o_set_hour  out  field widths  value to load; also the live edit value for display
- o_sel  out  2  field being edited: 0 none, 1 hour, 2 min, 3 sec

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- Reset values: state RUN, o_run_en 0, o_load 0, all o_set_* 0, o_sel 0.
- RUN:
  - o_run_en = 1.
  - i_mode: copy i_hour/i_min/i_sec into shadow registers (o_set_*), then go to SET_HOUR.
  - i_up, i_down and i_cancel are ignored.
- SET_x:
  - o_run_en = 0; o_sel shows the field.
  - i_up adds 1 with wrap: hour 23→0, min/sec 59→0.
  - i_down subtracts 1 with wrap: 0→23 or 0→59.
  - i_mode advances SET_HOUR→SET_MIN→SET_SEC→COMMIT.
- Input priority within a cycle: i_cancel > i_mode > (i_up/i_down).
  - i_up and i_down together: no change.
  - i_mode with i_up: the field advances and the increment is dropped.
- i_cancel in any SET state: go to RUN, no load. Shadow registers keep their stale values.
- COMMIT:
  - Lasts exactly one cycle, with o_load = 1 and o_set_* = shadow, then goes to RUN.
  - All button inputs in this cycle are ignored.
- Arithmetic: a field compare is a full-width equality against 23 or 59. Out-of-range captured values (for example hour 31) wrap to 0 on i_up and go to max-1 on i_down.

## Timing
- All outputs are registered.
- o_run_en = (next state is RUN), registered. After reset is released it rises at the first clk edge.
- i_mode sampled high in RUN at edge N:
  - the shadow is captured, o_sel = 1 and o_run_en = 0 after edge N;
  - the datapath misses at most one count.
- i_up at edge N: the field value updates after edge N (1-cycle latency).
- i_mode in SET_SEC at edge N: o_load is high from edge N to edge N+1, o_run_en = 1 after edge N+1, o_sel = 0 after edge N.
- The datapath must accept o_load regardless of o_run_en.
- reset asserted mid-edit: immediate return to the reset values, no load.

## Configuration
- WATCH_SET_CTRL_TIMEOUT_EN defined:
  - An idle counter (P_TIMEOUT_BIT wide) clears on entry to a SET state and on any accepted i_up/i_down/i_mode.
  - It counts every cycle in a SET state.
  - On reaching P_TIMEOUT_CYC-1 it behaves like i_cancel (to RUN, no load).
  - An explicit i_cancel or i_mode in the terminal cycle takes precedence.
- Undefined: no counter is built; the block waits in a SET state indefinitely.

## Structure
- Shared package watch_pkg holds:
  - the state enum (RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT);
  - the o_sel encodings;
  - the constants HOUR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59.
- One sub-module, watch_field_adj: a parameterised width/max up/down wrap adjuster with load. It is instantiated three times.

## Test plan
- Reset, then i_mode with time 12:34:56 → o_run_en 0 and o_sel 1 the next cycle; o_set = 12:34:56.
- SET_HOUR at 23, i_up → 0; SET_MIN at 0, i_down → 59; i_up and i_down together → unchanged.
- Full edit 12:34:56 → 13:33:57, then mode ×3 → exactly one o_load cycle carrying 13:33:57, then o_run_en 1 the next cycle.
- i_cancel in SET_MIN → RUN with no o_load; i_cancel together with i_mode → cancel wins.
- reset pulled low in SET_SEC → all outputs return to reset values asynchronously.
- With WATCH_SET_CTRL_TIMEOUT_EN and P_TIMEOUT_CYC = 16:
  - idle in SET_HOUR → RUN after 16 cycles, no load;
  - an i_up at cycle 10 restarts the count.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared states, field-select codes and field limits for the watch time-setting controller.
package watch_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } watch_state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  function automatic logic [1:0] sel_of(watch_state_e st);
    case (st)
      SET_HOUR: return SEL_HOUR;
      SET_MIN:  return SEL_MIN;
      SET_SEC:  return SEL_SEC;
      default:  return SEL_NONE;
    endcase
  endfunction

  // Field order the mode button walks through; the last field leads to the load cycle.
  function automatic watch_state_e next_field(watch_state_e st);
    case (st)
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return COMMIT;
    endcase
  endfunction

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Button-pulse inputs, current datapath time and set/load outputs of the time-setting controller.
interface watch_set_ctrl_if #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
);
  logic                  i_mode;
  logic                  i_up;
  logic                  i_down;
  logic                  i_cancel;
  logic [P_SEC_BIT-1:0]  i_sec;
  logic [P_MIN_BIT-1:0]  i_min;
  logic [P_HOUR_BIT-1:0] i_hour;
  logic                  o_run_en;
  logic                  o_load;
  logic [P_SEC_BIT-1:0]  o_set_sec;
  logic [P_MIN_BIT-1:0]  o_set_min;
  logic [P_HOUR_BIT-1:0] o_set_hour;
  logic [1:0]            o_sel;

  // Driven side: buttons and the datapath's current time.
  modport master (
    output i_mode, i_up, i_down, i_cancel, i_sec, i_min, i_hour,
    input  o_run_en, o_load, o_set_sec, o_set_min, o_set_hour, o_sel
  );

  modport slave (
    input  i_mode, i_up, i_down, i_cancel, i_sec, i_min, i_hour,
    output o_run_en, o_load, o_set_sec, o_set_min, o_set_hour, o_sel
  );
endinterface

// File: rtl/watch_field_adj.sv
// One time field: loadable shadow register that steps up/down with wrap between 0 and MAX.
module watch_field_adj #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] val_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] val_q, val_d;

  // Full-width equality: an out-of-range value steps by plain arithmetic.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: pauses the watch datapath, edits hour/min/sec, then loads them back.
// Optional inactivity abandon of an edit: define WATCH_SET_CTRL_TIMEOUT_EN.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int P_SEC_BIT     = 6,
  parameter int P_MIN_BIT     = 6,
  parameter int P_HOUR_BIT    = 5,
  parameter int P_TIMEOUT_BIT = 30,
  parameter int P_TIMEOUT_CYC = 1000000
) (
  input logic             clk,
  input logic             reset,
  watch_set_ctrl_if.slave bus
);
  watch_state_e state_q, state_d;
  logic         run_en_q;
  logic         load_q;
  logic [1:0]   sel_q;
  logic         in_set;
  logic         capture;
  logic         adj_ok;
  logic         timeout_hit;

  logic [P_HOUR_BIT-1:0] hour_val;
  logic [P_MIN_BIT-1:0]  min_val;
  logic [P_SEC_BIT-1:0]  sec_val;

  if (P_TIMEOUT_CYC < 2 || longint'(P_TIMEOUT_CYC) > (longint'(1) << P_TIMEOUT_BIT)) begin : g_bad_timeout
    $error("watch_set_ctrl: P_TIMEOUT_CYC does not fit P_TIMEOUT_BIT");
  end

  assign in_set  = state_q inside {SET_HOUR, SET_MIN, SET_SEC};
  assign capture = (state_q == RUN) && bus.i_mode;
  // Cancel, mode and timeout all outrank an edit; up+down together cancel each other out.
  assign adj_ok  = in_set && !bus.i_cancel && !bus.i_mode && !timeout_hit
                   && (bus.i_up ^ bus.i_down);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.i_mode) state_d = SET_HOUR;
      end
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (bus.i_cancel || (timeout_hit && !bus.i_mode)) state_d = RUN;
        else if (bus.i_mode)                              state_d = next_field(state_q);
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      run_en_q <= 1'b0;
      load_q   <= 1'b0;
      sel_q    <= SEL_NONE;
    end else begin
      state_q  <= state_d;
      run_en_q <= (state_d == RUN);
      load_q   <= (state_d == COMMIT);
      sel_q    <= sel_of(state_d);
    end
  end

`ifdef WATCH_SET_CTRL_TIMEOUT_EN
  localparam logic [P_TIMEOUT_BIT-1:0] IDLE_LAST = P_TIMEOUT_BIT'(P_TIMEOUT_CYC - 1);

  logic [P_TIMEOUT_BIT-1:0] idle_q, idle_d;

  assign timeout_hit = in_set && (idle_q == IDLE_LAST);

  // Held at zero outside the edit states, so every entry starts a fresh count.
  always_comb begin
    idle_d = idle_q + 1'b1;
    if (!in_set || bus.i_mode || bus.i_up || bus.i_down) idle_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  watch_field_adj #(.W(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
    .clk        (clk),
    .reset      (reset),
    .load_i     (capture),
    .load_val_i (bus.i_hour),
    .inc_i      (adj_ok && (state_q == SET_HOUR) && bus.i_up),
    .dec_i      (adj_ok && (state_q == SET_HOUR) && bus.i_down),
    .val_o      (hour_val)
  );

  watch_field_adj #(.W(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
    .clk        (clk),
    .reset      (reset),
    .load_i     (capture),
    .load_val_i (bus.i_min),
    .inc_i      (adj_ok && (state_q == SET_MIN) && bus.i_up),
    .dec_i      (adj_ok && (state_q == SET_MIN) && bus.i_down),
    .val_o      (min_val)
  );

  watch_field_adj #(.W(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .load_i     (capture),
    .load_val_i (bus.i_sec),
    .inc_i      (adj_ok && (state_q == SET_SEC) && bus.i_up),
    .dec_i      (adj_ok && (state_q == SET_SEC) && bus.i_down),
    .val_o      (sec_val)
  );

  assign bus.o_run_en   = run_en_q;
  assign bus.o_load     = load_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_set_hour = hour_val;
  assign bus.o_set_min  = min_val;
  assign bus.o_set_sec  = sec_val;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: a field/step reference model queues expected outputs,
// a negedge monitor pops and compares them and checks every load strobe against queued load values.
module tb_watch_set_ctrl;
  import watch_pkg::*;

  localparam int SB  = 6;
  localparam int MB  = 6;
  localparam int HB  = 5;
  localparam int TOB = 30;
  localparam int TOC = 16;
`ifdef WATCH_SET_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct { bit run_en; bit load; int sel; int h; int m; int s; } snap_t;
  typedef struct { int h; int m; int s; } time_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  watch_set_ctrl_if #(.P_SEC_BIT(SB), .P_MIN_BIT(MB), .P_HOUR_BIT(HB)) wif ();

  watch_set_ctrl #(
    .P_SEC_BIT     (SB),
    .P_MIN_BIT     (MB),
    .P_HOUR_BIT    (HB),
    .P_TIMEOUT_BIT (TOB),
    .P_TIMEOUT_CYC (TOC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  int    errors = 0;
  int    checks = 0;
  snap_t exp_q[$];
  time_t load_exp_q[$];

  // Reference model: st 0 = running, 1..3 = editing field st, 4 = load cycle.
  int st;
  int idle;
  int fld[4];
  int cur[4];
  int fmax[4] = '{0, HOUR_MAX, MIN_MAX, SEC_MAX};
  int fmod[4] = '{1, 1 << HB, 1 << MB, 1 << SB};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    st   = 0;
    idle = 0;
    for (int k = 0; k < 4; k++) fld[k] = 0;
  endtask

  task automatic model_step(input bit m, input bit u, input bit d, input bit c);
    snap_t sn;
    time_t ld;
    bit    to;
    to = TO_EN && (idle == TOC - 1);
    if (st == 0) begin
      if (m) begin
        for (int k = 1; k < 4; k++) fld[k] = cur[k];
        st   = 1;
        idle = 0;
      end
    end else if (st == 4) begin
      st = 0;
    end else begin
      if (c) begin
        st = 0;
      end else if (m) begin
        st   = st + 1;
        idle = 0;
        if (st == 4) begin
          ld.h = fld[1]; ld.m = fld[2]; ld.s = fld[3];
          load_exp_q.push_back(ld);
        end
      end else if (to) begin
        st = 0;
      end else begin
        if (u && !d)      fld[st] = (fld[st] == fmax[st]) ? 0 : (fld[st] + 1) % fmod[st];
        else if (d && !u) fld[st] = (fld[st] == 0) ? fmax[st] : fld[st] - 1;
        if (u || d) idle = 0;
        else        idle = idle + 1;
      end
    end
    sn.run_en = (st == 0);
    sn.load   = (st == 4);
    sn.sel    = (st >= 1 && st <= 3) ? st : 0;
    sn.h = fld[1]; sn.m = fld[2]; sn.s = fld[3];
    exp_q.push_back(sn);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur[1] = h; cur[2] = m; cur[3] = s;
    wif.i_hour = HB'(h);
    wif.i_min  = MB'(m);
    wif.i_sec  = SB'(s);
  endtask

  // One clock of stimulus: buttons held across exactly one rising edge.
  task automatic cyc(input bit m, input bit u, input bit d, input bit c);
    wif.i_mode = m; wif.i_up = u; wif.i_down = d; wif.i_cancel = c;
    @(posedge clk);
    model_step(m, u, d, c);
    #1;
    wif.i_mode = 1'b0; wif.i_up = 1'b0; wif.i_down = 1'b0; wif.i_cancel = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_run_en"}, int'(wif.o_run_en),   0);
    chk({tag, "_load"},   int'(wif.o_load),     0);
    chk({tag, "_sel"},    int'(wif.o_sel),      0);
    chk({tag, "_hour"},   int'(wif.o_set_hour), 0);
    chk({tag, "_min"},    int'(wif.o_set_min),  0);
    chk({tag, "_sec"},    int'(wif.o_set_sec),  0);
  endtask

  always @(negedge clk) begin
    snap_t e;
    time_t l;
    if (reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("run_en", int'(wif.o_run_en),   int'(e.run_en));
        chk("load",   int'(wif.o_load),     int'(e.load));
        chk("sel",    int'(wif.o_sel),      e.sel);
        chk("hour",   int'(wif.o_set_hour), e.h);
        chk("min",    int'(wif.o_set_min),  e.m);
        chk("sec",    int'(wif.o_set_sec),  e.s);
      end
      if (wif.o_load === 1'b1) begin
        chk("load_expected", int'(load_exp_q.size() > 0), 1);
        if (load_exp_q.size() > 0) begin
          l = load_exp_q.pop_front();
          chk("load_time",
              int'(wif.o_set_hour) * 3600 + int'(wif.o_set_min) * 60 + int'(wif.o_set_sec),
              l.h * 3600 + l.m * 60 + l.s);
        end
      end
    end
  end

  initial begin
    int r;
    wif.i_mode = 1'b0; wif.i_up = 1'b0; wif.i_down = 1'b0; wif.i_cancel = 1'b0;
    set_time(0, 0, 0);
    model_reset();
    #1 reset = 1'b0;
    #3;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Capture 12:34:56 and edit to 13:33:57, then commit.
    set_time(12, 34, 56);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Wrap boundaries, mode+up, up+down, cancel paths.
    set_time(23, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    set_time(5, 10, 59);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Idle abandonment and restart of the idle count by an edit.
    if (TO_EN) begin
      cyc(1, 0, 0, 0);
      repeat (20) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (9) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      repeat (20) cyc(0, 0, 0, 0);
    end

    for (int i = 0; i < 400; i++) begin
      set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      r = $urandom_range(0, 99);
      if (r < 30) cyc(0, 0, 0, 0);
      else        cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (3) cyc(0, 0, 0, 0);

    // Asynchronous reset in the middle of editing seconds.
    set_time(7, 8, 9);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("arst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("load_q_drained", load_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
